// File: rtl/tcn_fifo_address_sequencer.sv
// Read/write address sequencer for the TCN activation FIFO remapper.
// Optional read-bounds checking is compiled in with `define TCN_SEQ_BOUNDS_CHECK_EN.
module tcn_fifo_address_sequencer #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_TAPS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       cfg_rd_block_size,
  input  logic [15:0]       cfg_wr_block_size,
  input  logic [ADDR_W-1:0] cfg_total_blocks,
  input  logic [4:0]        cfg_num_taps,
  input  logic [7:0]        cfg_dilation,
  input  logic [15:0]       cfg_num_steps,
  input  logic              rd_stall,
  input  logic              wr_valid,
  output logic [ADDR_W-1:0] rd_address,
  output logic [ADDR_W-1:0] wr_address,
  output logic              rd_enable,
  output logic              wr_enable,
  output logic              update_pointer,
  output logic              busy,
  output logic              done,
  output logic              cfg_error
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StUpd, StSettle, StDone} state_e;

  state_e             st_q, st_d;
  logic [15:0]        rd_bs_q, rd_bs_d, wr_bs_q, wr_bs_d, steps_q, steps_d;
  logic [4:0]         taps_q, taps_d;
  logic [7:0]         dil_q, dil_d;
  logic [4:0]         tap_q, tap_d;
  logic [15:0]        word_q, word_d, step_q, step_d;
  logic               settle_q, settle_d;
  logic [ADDR_W-1:0]  rd_address_q, rd_address_d, wr_address_q, wr_address_d;
  logic               rd_enable_q, rd_enable_d, wr_enable_q, wr_enable_d;
  logic               update_pointer_q, update_pointer_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [4:0]         taps_in;
  logic [15:0]        steps_in;
  logic [15:0]        rd_bs_c;
  logic [4:0]         taps_c, tap_c;
  logic [7:0]         dil_c;
  logic [15:0]        word_c;
  logic               idle;
  logic               do_rd;

  always_comb begin
    taps_in = cfg_num_taps;
    if (cfg_num_taps == 5'd0) begin
      taps_in = 5'd1;
    end else if (32'(cfg_num_taps) > MAX_TAPS) begin
      taps_in = 5'(MAX_TAPS);
    end
  end

  assign steps_in = (cfg_num_steps == 16'd0) ? 16'd1 : cfg_num_steps;

  // The first read issues on the start edge, before the config registers are loaded.
  assign idle    = (st_q == StIdle);
  assign rd_bs_c = idle ? cfg_rd_block_size : rd_bs_q;
  assign taps_c  = idle ? taps_in : taps_q;
  assign dil_c   = idle ? cfg_dilation : dil_q;
  assign tap_c   = idle ? 5'd0 : tap_q;
  assign word_c  = idle ? 16'd0 : word_q;

  always_comb begin
    st_d             = st_q;
    rd_bs_d          = rd_bs_q;
    wr_bs_d          = wr_bs_q;
    steps_d          = steps_q;
    taps_d           = taps_q;
    dil_d            = dil_q;
    tap_d            = tap_q;
    word_d           = word_q;
    step_d           = step_q;
    settle_d         = settle_q;
    rd_address_d     = rd_address_q;
    wr_address_d     = wr_address_q;
    rd_enable_d      = 1'b0;
    wr_enable_d      = 1'b0;
    update_pointer_d = 1'b0;
    busy_d           = busy_q;
    done_d           = 1'b0;
    do_rd            = 1'b0;

    case (st_q)
      StIdle: begin
        if (start) begin
          rd_bs_d  = cfg_rd_block_size;
          wr_bs_d  = cfg_wr_block_size;
          steps_d  = steps_in;
          taps_d   = taps_in;
          dil_d    = cfg_dilation;
          tap_d    = 5'd0;
          word_d   = 16'd0;
          step_d   = 16'd0;
          settle_d = 1'b0;
          busy_d   = 1'b1;
          st_d     = StRd;
          do_rd    = 1'b1;
        end
      end
      StRd: do_rd = 1'b1;
      StWr: begin
        if (wr_bs_q == 16'd0) begin
          st_d = StUpd;
        end else if (wr_valid) begin
          wr_enable_d  = 1'b1;
          wr_address_d = ADDR_W'(word_q);
          if (word_q == wr_bs_q - 16'd1) begin
            word_d = 16'd0;
            st_d   = StUpd;
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      StUpd: begin
        update_pointer_d = 1'b1;
        settle_d         = 1'b0;
        st_d             = StSettle;
      end
      StSettle: begin
        if (!settle_q) begin
          settle_d = 1'b1;
        end else begin
          step_d = step_q + 16'd1;
          tap_d  = 5'd0;
          word_d = 16'd0;
          if (({1'b0, step_q} + 17'd1) >= {1'b0, steps_q}) begin
            st_d = StDone;
          end else begin
            st_d = StRd;
          end
        end
      end
      StDone: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = StIdle;
      end
      default: st_d = StIdle;
    endcase

    if (do_rd) begin
      if (rd_bs_c == 16'd0) begin
        tap_d  = 5'd0;
        word_d = 16'd0;
        st_d   = StWr;
      end else if (!rd_stall) begin
        rd_enable_d  = 1'b1;
        rd_address_d = ADDR_W'(32'(tap_c) * 32'(dil_c) * 32'(rd_bs_c) + 32'(word_c));
        if (word_c == rd_bs_c - 16'd1) begin
          word_d = 16'd0;
          if (tap_c == taps_c - 5'd1) begin
            tap_d = 5'd0;
            st_d  = StWr;
          end else begin
            tap_d = tap_c + 5'd1;
          end
        end else begin
          word_d = word_c + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q             <= StIdle;
      rd_bs_q          <= '0;
      wr_bs_q          <= '0;
      steps_q          <= '0;
      taps_q           <= '0;
      dil_q            <= '0;
      tap_q            <= '0;
      word_q           <= '0;
      step_q           <= '0;
      settle_q         <= 1'b0;
      rd_address_q     <= '0;
      wr_address_q     <= '0;
      rd_enable_q      <= 1'b0;
      wr_enable_q      <= 1'b0;
      update_pointer_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      st_q             <= st_d;
      rd_bs_q          <= rd_bs_d;
      wr_bs_q          <= wr_bs_d;
      steps_q          <= steps_d;
      taps_q           <= taps_d;
      dil_q            <= dil_d;
      tap_q            <= tap_d;
      word_q           <= word_d;
      step_q           <= step_d;
      settle_q         <= settle_d;
      rd_address_q     <= rd_address_d;
      wr_address_q     <= wr_address_d;
      rd_enable_q      <= rd_enable_d;
      wr_enable_q      <= wr_enable_d;
      update_pointer_q <= update_pointer_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

`ifdef TCN_SEQ_BOUNDS_CHECK_EN
  logic cfg_error_q, cfg_error_d;

  // Sticky: only reset clears it, later clean configs do not.
  always_comb begin
    cfg_error_d = cfg_error_q;
    if (idle && start &&
        ((32'(taps_in - 5'd1) * 32'(cfg_dilation)) >= 32'(cfg_total_blocks))) begin
      cfg_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_error_q <= 1'b0;
    end else begin
      cfg_error_q <= cfg_error_d;
    end
  end

  assign cfg_error = cfg_error_q;
`else
  logic unused_total_blocks;
  assign unused_total_blocks = ^cfg_total_blocks;
  assign cfg_error = 1'b0;
`endif

  assign rd_address     = rd_address_q;
  assign wr_address     = wr_address_q;
  assign rd_enable      = rd_enable_q;
  assign wr_enable      = wr_enable_q;
  assign update_pointer = update_pointer_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_tcn_fifo_address_sequencer.sv
// Scoreboard bench for tcn_fifo_address_sequencer: directed configs with hand-computed
// address/cycle expectations, checked by an independent output monitor.
module tb_tcn_fifo_address_sequencer;

`ifdef TCN_SEQ_BOUNDS_CHECK_EN
  localparam int ExpErr = 1;
`else
  localparam int ExpErr = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_rd_block_size = '0;
  logic [15:0] cfg_wr_block_size = '0;
  logic [13:0] cfg_total_blocks = '0;
  logic [4:0]  cfg_num_taps = '0;
  logic [7:0]  cfg_dilation = '0;
  logic [15:0] cfg_num_steps = '0;
  logic        rd_stall = 1'b0;
  logic        wr_valid = 1'b0;
  logic [13:0] rd_address, wr_address;
  logic        rd_enable, wr_enable, update_pointer, busy, done, cfg_error;

  tcn_fifo_address_sequencer #(.ADDR_W(14), .MAX_TAPS(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_rd_block_size(cfg_rd_block_size),
    .cfg_wr_block_size(cfg_wr_block_size),
    .cfg_total_blocks (cfg_total_blocks),
    .cfg_num_taps     (cfg_num_taps),
    .cfg_dilation     (cfg_dilation),
    .cfg_num_steps    (cfg_num_steps),
    .rd_stall         (rd_stall),
    .wr_valid         (wr_valid),
    .rd_address       (rd_address),
    .wr_address       (wr_address),
    .rd_enable        (rd_enable),
    .wr_enable        (wr_enable),
    .update_pointer   (update_pointer),
    .busy             (busy),
    .done             (done),
    .cfg_error        (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rel;
    int addr;
  } exp_t;

  exp_t exp_rd[$];
  exp_t exp_wr[$];
  int   exp_upd[$];
  int   exp_done[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: rel is the cycle index counted from the cycle in which start was high.
  always @(negedge clk) begin
    int   rel;
    exp_t e;
    int   w;
    rel = cyc - start_cyc;
    if (rd_enable) begin
      tests++;
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL rd_extra: got rel=%0d addr=%0d, none expected", rel, rd_address);
      end else begin
        e = exp_rd.pop_front();
        if (e.rel != rel || e.addr != int'(rd_address)) begin
          fails++;
          $display("FAIL rd: got rel=%0d addr=%0d, want rel=%0d addr=%0d",
                   rel, rd_address, e.rel, e.addr);
        end
      end
    end
    if (wr_enable) begin
      tests++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL wr_extra: got rel=%0d addr=%0d, none expected", rel, wr_address);
      end else begin
        e = exp_wr.pop_front();
        if (e.rel != rel || e.addr != int'(wr_address)) begin
          fails++;
          $display("FAIL wr: got rel=%0d addr=%0d, want rel=%0d addr=%0d",
                   rel, wr_address, e.rel, e.addr);
        end
      end
    end
    if (update_pointer) begin
      tests++;
      if (exp_upd.size() == 0) begin
        fails++;
        $display("FAIL upd_extra: got pulse at rel=%0d, none expected", rel);
      end else begin
        w = exp_upd.pop_front();
        if (w != rel) begin
          fails++;
          $display("FAIL upd: got rel=%0d want rel=%0d", rel, w);
        end
      end
    end
    if (rd_enable || wr_enable || update_pointer) begin
      tests++;
      if ($countones({rd_enable, wr_enable, update_pointer}) > 1) begin
        fails++;
        $display("FAIL strobe_excl: got rd=%0b wr=%0b upd=%0b, want at most one",
                 rd_enable, wr_enable, update_pointer);
      end
    end
    if (done) begin
      done_cnt++;
      tests++;
      if (exp_done.size() == 0) begin
        fails++;
        $display("FAIL done_extra: got done at rel=%0d, none expected", rel);
      end else begin
        w = exp_done.pop_front();
        if (w != rel || busy) begin
          fails++;
          $display("FAIL done: got rel=%0d busy=%0b, want rel=%0d busy=0", rel, busy, w);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_rd(input int rel, input int addr);
    exp_t e;
    e.rel = rel;
    e.addr = addr;
    exp_rd.push_back(e);
  endtask

  task automatic push_wr(input int rel, input int addr);
    exp_t e;
    e.rel = rel;
    e.addr = addr;
    exp_wr.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step_to(input int n);
    while ((cyc - start_cyc) < n) tick();
  endtask

  task automatic start_seq(input int rbs, input int wbs, input int total, input int taps,
                           input int dil, input int steps);
    tick();
    cfg_rd_block_size = 16'(rbs);
    cfg_wr_block_size = 16'(wbs);
    cfg_total_blocks  = 14'(total);
    cfg_num_taps      = 5'(taps);
    cfg_dilation      = 8'(dil);
    cfg_num_steps     = 16'(steps);
    start_cyc         = cyc;
    start             = 1'b1;
    tick();
    start             = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int seen;
    bit got;
    seen = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != seen) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(got), 1);
    tick();
    tick();
  endtask

  task automatic check_empty(input string name);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_wr_left"}, exp_wr.size(), 0);
    chk({name, "_upd_left"}, exp_upd.size(), 0);
    chk({name, "_done_left"}, exp_done.size(), 0);
    exp_rd.delete();
    exp_wr.delete();
    exp_upd.delete();
    exp_done.delete();
  endtask

  initial begin
    tick();
    tick();
    chk("reset_strobes", int'({rd_enable, wr_enable, update_pointer, busy, done, cfg_error}), 0);
    chk("reset_addr", int'(rd_address) + int'(wr_address), 0);
    reset = 1'b1;
    wr_valid = 1'b1;
    tick();

    // A: K=3, dilation=2, rd=4, wr=2, one step, no stalls.
    for (int t = 0; t < 3; t++)
      for (int w = 0; w < 4; w++) push_rd(1 + t * 4 + w, t * 8 + w);
    push_wr(13, 0);
    push_wr(14, 1);
    exp_upd.push_back(15);
    exp_done.push_back(18);
    start_seq(4, 2, 16, 3, 2, 1);
    chk("a_busy_cycle1", int'(busy), 1);
    wait_done("a", 100);
    chk("a_busy_after", int'(busy), 0);
    chk("a_cfg_error", int'(cfg_error), 0);
    check_empty("a");

    // B: same config, rd_stall high during cycles 5..7 -> no reads in 6..8.
    for (int i = 0; i < 12; i++) push_rd((i < 5) ? 1 + i : 4 + i, (i / 4) * 8 + (i % 4));
    push_wr(16, 0);
    push_wr(17, 1);
    exp_upd.push_back(18);
    exp_done.push_back(21);
    start_seq(4, 2, 16, 3, 2, 1);
    step_to(5);
    rd_stall = 1'b1;
    step_to(7);
    chk("b_addr_held", int'(rd_address), 8);
    step_to(8);
    rd_stall = 1'b0;
    wait_done("b", 100);
    check_empty("b");

    // C: wr_valid 1,0,1 during the write phase.
    wr_valid = 1'b0;
    push_rd(1, 0);
    push_rd(2, 1);
    push_wr(3, 0);
    push_wr(5, 1);
    exp_upd.push_back(6);
    exp_done.push_back(9);
    start_seq(2, 2, 16, 1, 1, 1);
    step_to(2);
    wr_valid = 1'b1;
    step_to(3);
    wr_valid = 1'b0;
    step_to(4);
    wr_valid = 1'b1;
    step_to(5);
    wr_valid = 1'b0;
    wait_done("c", 100);
    check_empty("c");

    // D: three steps, 8 cycles each; settle gap checked through exact read cycles.
    wr_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 4; i++) push_rd(1 + 8 * s + i, i);
      push_wr(5 + 8 * s, 0);
      exp_upd.push_back(6 + 8 * s);
    end
    exp_done.push_back(25);
    start_seq(2, 1, 8, 2, 1, 3);
    wait_done("d", 100);
    chk("d_cfg_error", int'(cfg_error), 0);
    check_empty("d");

    // E: reset while waiting in the write phase of the second step.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) push_rd(1 + 8 * s + i, i);
    push_wr(5, 0);
    exp_upd.push_back(6);
    start_seq(2, 1, 8, 2, 1, 3);
    step_to(12);
    wr_valid = 1'b0;
    step_to(13);
    reset = 1'b0;
    step_to(14);
    chk("e_rst_strobes", int'({rd_enable, wr_enable, update_pointer, busy, done, cfg_error}), 0);
    chk("e_rst_addr", int'(rd_address) + int'(wr_address), 0);
    step_to(16);
    reset = 1'b1;
    wr_valid = 1'b1;
    step_to(20);
    check_empty("e");

    // E2: fresh start after reset runs from step 0.
    for (int i = 0; i < 4; i++) push_rd(1 + i, i);
    push_wr(5, 0);
    exp_upd.push_back(6);
    exp_done.push_back(9);
    start_seq(2, 1, 8, 2, 1, 1);
    wait_done("e2", 100);
    check_empty("e2");

    // F: (K-1)*dilation = 8 >= 8 total blocks.
    for (int t = 0; t < 5; t++) push_rd(1 + t, 2 * t);
    push_wr(6, 0);
    exp_upd.push_back(7);
    exp_done.push_back(10);
    start_seq(1, 1, 8, 5, 2, 1);
    chk("f_cfg_error_early", int'(cfg_error), ExpErr);
    wait_done("f", 100);
    chk("f_cfg_error_after_done", int'(cfg_error), ExpErr);
    tick();
    tick();
    chk("f_cfg_error_sticky", int'(cfg_error), ExpErr);
    check_empty("f");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
